// File: rtl/raster_timing_gen_pkg.sv
// Shared types and helpers for the raster timing generator: FSM state
// encoding, region-total arithmetic and sync-window decode.
package raster_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int unsigned region_total(
        input int unsigned act,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return act + fp + sync + bp;
    endfunction

    // Sync sits after active + front porch; returns the output line level.
    function automatic logic sync_level(
        input int unsigned pos,
        input int unsigned act,
        input int unsigned fp,
        input int unsigned sync,
        input logic        pol
    );
        logic in_win;
        in_win = (pos >= act + fp) && (pos < act + fp + sync);
        return in_win ? pol : ~pol;
    endfunction

endpackage

// File: rtl/raster_timing_gen_axis.sv
// Wrapping position counter with inclusive maximum; one instance per raster axis.
module axis_counter #(
    parameter int unsigned W   = 10,
    parameter int unsigned MAX = 799
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         at_max
);

    localparam logic [W-1:0] MAX_W = W'(MAX);

    logic [W-1:0] count_r;

    // Position register: clear beats enable, wraps to zero after MAX
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (en) begin
            if (count_r == MAX_W) begin
                count_r <= {W{1'b0}};
            end else begin
                count_r <= count_r + W'(1);
            end
        end
    end

    assign count  = count_r;
    assign at_max = (count_r == MAX_W);

endmodule

// File: rtl/raster_timing_gen.sv
// Raster timing generator: IDLE/RUN control around two axis counters, with
// all outputs decoded from registered state so no input reaches an output.
module raster_timing_gen import raster_pkg::*; #(
    parameter int unsigned XW       = 10,
    parameter int unsigned YW       = 10,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          pix_en,
    input  logic          clear,
    input  logic          cont,
    input  logic          start,
    output logic [XW-1:0] h_count,
    output logic [YW-1:0] v_count,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          line_end,
    output logic          frame_end,
    output logic          frame_start,
    output logic          busy
);

    localparam int unsigned H_TOTAL = region_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = region_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam longint unsigned H_LIMIT = 64'd1 << XW;
    localparam longint unsigned V_LIMIT = 64'd1 << YW;
    localparam logic [XW:0] H_ACT_L = (XW+1)'(H_ACTIVE);
    localparam logic [YW:0] V_ACT_L = (YW+1)'(V_ACTIVE);

    if (64'(H_TOTAL) > H_LIMIT) begin : g_h_width_chk
        $error("raster_timing_gen: H_TOTAL does not fit in XW bits");
    end
    if (64'(V_TOTAL) > V_LIMIT) begin : g_v_width_chk
        $error("raster_timing_gen: V_TOTAL does not fit in YW bits");
    end

    state_e        state_r;
    state_e        state_next_s;
    logic          run_s;
    logic          h_en_s;
    logic          v_en_s;
    logic          h_at_max_s;
    logic          v_at_max_s;
    logic [XW-1:0] h_count_s;
    logic [YW-1:0] v_count_s;
    logic          active_s;

    assign run_s  = (state_r == ST_RUN);
    assign h_en_s = run_s & pix_en;
    assign v_en_s = h_en_s & h_at_max_s;

    axis_counter #(.W(XW), .MAX(H_TOTAL - 1)) u_h_cnt (
        .clk    (clk),
        .nrst   (nrst),
        .clr    (clear),
        .en     (h_en_s),
        .count  (h_count_s),
        .at_max (h_at_max_s)
    );

    axis_counter #(.W(YW), .MAX(V_TOTAL - 1)) u_v_cnt (
        .clk    (clk),
        .nrst   (nrst),
        .clr    (clear),
        .en     (v_en_s),
        .count  (v_count_s),
        .at_max (v_at_max_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: clear dominates; cont is sampled only at the frame-end pixel
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clear) begin
                    state_next_s = ST_IDLE;
                end else if (cont || start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_next_s = ST_IDLE;
                end else if (pix_en && h_at_max_s && v_at_max_s && !cont) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    assign active_s = run_s && ({1'b0, h_count_s} < H_ACT_L)
                            && ({1'b0, v_count_s} < V_ACT_L);

    assign h_count     = h_count_s;
    assign v_count     = v_count_s;
    assign active      = active_s;
    assign x           = active_s ? h_count_s : {XW{1'b0}};
    assign y           = active_s ? v_count_s : {YW{1'b0}};
    assign hsync       = sync_level(32'(h_count_s), H_ACTIVE, H_FP, H_SYNC, SYNC_POL);
    assign vsync       = sync_level(32'(v_count_s), V_ACTIVE, V_FP, V_SYNC, SYNC_POL);
    assign line_end    = run_s && h_at_max_s;
    assign frame_end   = run_s && h_at_max_s && v_at_max_s;
    assign frame_start = run_s && (h_count_s == {XW{1'b0}}) && (v_count_s == {YW{1'b0}});
    assign busy        = run_s;

endmodule

// File: tb/tb_raster_timing_gen.sv
// Randomised bench for raster_timing_gen on an 8x6 raster, checked against a
// linear pixel-index model of the frame.
module tb_raster_timing_gen;

    localparam int HT = 8;
    localparam int VT = 6;
    localparam int NPIX = HT * VT;

    logic       clk = 1'b0;
    logic       nrst, pix_en, clear, cont, start;
    logic [3:0] h_count, v_count, x, y;
    logic       active, hsync, vsync, line_end, frame_end, frame_start, busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: running flag plus pixel index into the frame
    bit m_run = 1'b0;
    int m_p   = 0;

    raster_timing_gen #(
        .XW(4), .YW(4),
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .nrst(nrst), .pix_en(pix_en), .clear(clear), .cont(cont),
        .start(start), .h_count(h_count), .v_count(v_count), .x(x), .y(y),
        .active(active), .hsync(hsync), .vsync(vsync), .line_end(line_end),
        .frame_end(frame_end), .frame_start(frame_start), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int  h, v;
        bit  act;
        h   = m_p % HT;
        v   = m_p / HT;
        act = m_run && (h < 4) && (v < 3);
        chk("h_count", h_count, m_run ? h : 0);
        chk("v_count", v_count, m_run ? v : 0);
        chk("active", active, act);
        chk("x", x, act ? h : 0);
        chk("y", y, act ? v : 0);
        chk("hsync", hsync, !(h >= 5 && h <= 6));
        chk("vsync", vsync, !(v == 4));
        chk("line_end", line_end, m_run && h == HT - 1);
        chk("frame_end", frame_end, m_run && m_p == NPIX - 1);
        chk("frame_start", frame_start, m_run && m_p == 0);
        chk("busy", busy, m_run);
    endtask

    task automatic step(input logic pe, input logic cl, input logic co, input logic st);
        pix_en = pe;
        clear  = cl;
        cont   = co;
        start  = st;
        @(posedge clk);
        if (cl) begin
            m_run = 1'b0;
            m_p   = 0;
        end else if (!m_run) begin
            if (co || st) m_run = 1'b1;
        end else if (pe) begin
            if (m_p == NPIX - 1) begin
                m_p   = 0;
                m_run = co;
            end else begin
                m_p++;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        int strobes, guard, act_cnt;
        nrst = 1'b0; pix_en = 1'b0; clear = 1'b0; cont = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #3 nrst = 1'b1;

        // Continuous frames with pix_en every cycle
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t1_frame_start", frame_start, 1'b1);
        act_cnt = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (active) act_cnt++;
            step(1'b1, 1'b0, 1'b1, 1'b0);
        end
        chk("t1_active_per_frame", act_cnt, 12);
        for (int i = 0; i < NPIX + 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0);

        // Drop cont mid-frame: current frame completes, then IDLE
        for (int i = 0; i < 2 * NPIX; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_idle_after_cont_drop", busy, 1'b0);

        // One-shot frame with fixed and random pix_en, start pulses mid-frame
        for (int pass = 0; pass < 3; pass++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            strobes = 0;
            guard   = 0;
            while (busy && guard < 400) begin
                logic pe;
                pe = (pass == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                if (pe) strobes++;
                step(pe, 1'b0, 1'b0, (pass == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
                guard++;
            end
            chk("oneshot_timeout", guard < 400, 1'b1);
            chk("oneshot_strobes", strobes, NPIX);
            for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Clear at (5,2), then clear together with start in IDLE
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2 * HT + 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4_pre_h", h_count, 5);
        chk("t4_pre_v", v_count, 2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_clear_busy", busy, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t4_clear_start_busy", busy, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Random mix of all controls
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset mid-frame
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        #3 nrst = 1'b0;
        #1;
        m_run = 1'b0;
        m_p   = 0;
        check_all();
        chk("t6_async_busy", busy, 1'b0);
        @(posedge clk);
        #1 check_all();
        cont = 1'b0;
        #2 nrst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
